// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-lite widths, response codes and bridge FSM states
package axi_lite_pkg;
  localparam int AXIL_AWIDTH = 32;
  localparam int AXIL_DWIDTH = 32;
  localparam int AXIL_SWIDTH = 4;
  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} axi_resp_t;
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, DRAIN} axi_mst_state_t;
endpackage

// File: rtl/axi4lite_intf.sv
// axi4lite_intf: AXI4-lite bus between one master and one slave
interface axi4lite_intf;
  import axi_lite_pkg::*;
  logic [AXIL_AWIDTH-1:0] awaddr, araddr;
  logic [AXIL_DWIDTH-1:0] wdata, rdata;
  logic [AXIL_SWIDTH-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge: single-outstanding request/response port to AXI4-lite master with timeout
module axi_lite_master_bridge
  import axi_lite_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [AWIDTH-1:0]      req_addr,
  input  logic [AXIL_DWIDTH-1:0] req_wdata,
  input  logic [AXIL_SWIDTH-1:0] req_wstrb,
  output logic                   rsp_valid,
  output logic [AXIL_DWIDTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  axi4lite_intf.master           axi
);
  axi_mst_state_t state, state_n;
  logic is_write, a_done, w_done, r_got;
  logic [1:0] resp_q, resp;
  logic [AXIL_DWIDTH-1:0] rdata_q, rdata;
  logic [31:0] timer;
  logic accept, busy, a_hs, w_hs, r_hs, a_dn, w_dn, r_dn, done, expire;
  assign req_ready = state == IDLE;
  // a_* tracks AW for writes and AR for reads; w_done is preset for reads
  always_comb begin
    accept = req_valid && req_ready;
    busy = state inside {WR, WR_RESP, RD, RD_DATA};
    a_hs = is_write ? axi.awvalid && axi.awready : axi.arvalid && axi.arready;
    w_hs = axi.wvalid && axi.wready;
    r_hs = is_write ? axi.bvalid && axi.bready : axi.rvalid && axi.rready;
    a_dn = a_done || a_hs;
    w_dn = w_done || w_hs;
    r_dn = r_got || r_hs;
    done = a_dn && w_dn && r_dn;
    expire = TIMEOUT != 0 && timer == TIMEOUT - 1;
    resp = r_hs ? (is_write ? axi.bresp : axi.rresp) : resp_q;
    rdata = r_hs ? axi.rdata : rdata_q;
    state_n = state;
    case (state)
      IDLE:             state_n = accept ? (req_write ? WR : RD) : IDLE;
      WR:               state_n = done ? IDLE : expire ? DRAIN : (a_dn && w_dn) ? WR_RESP : WR;
      RD:               state_n = done ? IDLE : expire ? DRAIN : a_dn ? RD_DATA : RD;
      WR_RESP, RD_DATA: state_n = done ? IDLE : expire ? DRAIN : state;
      DRAIN:            state_n = done ? IDLE : DRAIN;
      default:          state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      is_write <= 1'b0;
      a_done <= 1'b0;
      w_done <= 1'b0;
      r_got <= 1'b0;
      resp_q <= '0;
      rdata_q <= '0;
      timer <= '0;
      axi.awvalid <= 1'b0;
      axi.wvalid <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.bready <= 1'b0;
      axi.rready <= 1'b0;
      axi.awaddr <= '0;
      axi.araddr <= '0;
      axi.wdata <= '0;
      axi.wstrb <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_n;
      rsp_valid <= 1'b0;
      resp_q <= resp;
      rdata_q <= rdata;
      if (accept) begin
        is_write <= req_write;
        a_done <= 1'b0;
        w_done <= !req_write;
        r_got <= 1'b0;
        timer <= '0;
        axi.awvalid <= req_write;
        axi.wvalid <= req_write;
        axi.arvalid <= !req_write;
        axi.bready <= req_write;
        axi.rready <= !req_write;
        axi.awaddr <= AXIL_AWIDTH'(req_addr);
        axi.araddr <= AXIL_AWIDTH'(req_addr);
        axi.wdata <= req_wdata;
        axi.wstrb <= req_wstrb;
      end else begin
        timer <= busy ? timer + 1 : timer;
        a_done <= a_dn;
        w_done <= w_dn;
        r_got <= r_dn;
        axi.awvalid <= axi.awvalid && !axi.awready;
        axi.wvalid <= axi.wvalid && !axi.wready;
        axi.arvalid <= axi.arvalid && !axi.arready;
        axi.bready <= axi.bready && state_n != IDLE;
        axi.rready <= axi.rready && state_n != IDLE;
      end
      // a completion in the expiry cycle takes priority over the timeout
      if (busy && done) begin
        rsp_valid <= 1'b1;
        rsp_err <= resp != OKAY;
        rsp_timeout <= 1'b0;
        rsp_rdata <= is_write ? '0 : rdata;
      end else if (busy && expire) begin
        rsp_valid <= 1'b1;
        rsp_err <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// tb_axi_lite_master_bridge: directed checks of the bridge against a stallable AXI-lite RAM slave
module tb_axi_lite_master_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_wstrb = '0;
  logic req_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  int errors = 0, checks = 0;
  axi4lite_intf axi();
  axi_lite_master_bridge #(.AWIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .axi(axi)
  );
  always #5 clk = ~clk;
  // slave: 2 KiB RAM with configurable awready stall, arready block and SLVERR at 0x40
  logic [31:0] mem [512];
  int aw_wait = 0;
  bit ar_block = 0, r_err = 0;
  int aw_cnt;
  logic aw_got, w_got;
  logic [31:0] aw_a, w_d;
  logic [3:0] w_s;
  assign axi.awready = !aw_got && aw_cnt >= aw_wait;
  assign axi.wready = !w_got;
  assign axi.arready = !ar_block && !axi.rvalid;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; aw_got <= 0; w_got <= 0; aw_a <= 0; w_d <= 0; w_s <= 0;
      axi.bvalid <= 0; axi.bresp <= 0; axi.rvalid <= 0; axi.rresp <= 0; axi.rdata <= 0;
    end else begin
      aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
      if (axi.awvalid && axi.awready) begin aw_got <= 1; aw_a <= axi.awaddr; end
      if (axi.wvalid && axi.wready) begin w_got <= 1; w_d <= axi.wdata; w_s <= axi.wstrb; end
      if (aw_got && w_got && !axi.bvalid) begin
        for (int i = 0; i < 4; i++) if (w_s[i]) mem[aw_a[10:2]][8*i +: 8] <= w_d[8*i +: 8];
        aw_got <= 0; w_got <= 0; axi.bvalid <= 1; axi.bresp <= 2'b00;
      end else if (axi.bvalid && axi.bready) axi.bvalid <= 0;
      if (axi.arvalid && axi.arready) begin
        axi.rvalid <= 1;
        axi.rdata <= mem[axi.araddr[10:2]];
        axi.rresp <= (r_err && axi.araddr == 32'h40) ? 2'b10 : 2'b00;
      end else if (axi.rvalid && axi.rready) axi.rvalid <= 0;
    end
  end
  // monitors
  int rsp_cnt = 0, acc_cnt = 0, aw_hi = 0, w_hi = 0, aw_moves = 0;
  logic prev_awv = 0;
  logic [31:0] prev_awaddr = 0;
  always @(posedge clk) if (req_valid && req_ready) acc_cnt++;
  always @(negedge clk) begin
    if (rsp_valid) rsp_cnt++;
    if (axi.wvalid) w_hi++;
    if (axi.awvalid) begin
      aw_hi++;
      if (prev_awv && axi.awaddr !== prev_awaddr) aw_moves++;
    end
    prev_awv = axi.awvalid;
    prev_awaddr = axi.awaddr;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end
  logic got_v, got_e, got_t;
  logic [31:0] got_d;
  int got_lat;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // issue one request from idle, wait (bounded) for rsp_valid; got_lat = cycles after accept
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    got_v = rsp_valid; got_d = rsp_rdata; got_e = rsp_err; got_t = rsp_timeout; got_lat = n;
  endtask
  int base_rsp, base_aw, base_w, base_mv, base_acc, n;
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_timeout", rsp_timeout, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    // basic write then read
    base_rsp = rsp_cnt;
    xact(1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("wr10_valid", got_v, 1);
    chk("wr10_err", got_e, 0);
    chk("wr10_rdata_zero", got_d, 0);
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 0);
    xact(0, 32'h10, 0, 0);
    chk("rd10_valid", got_v, 1);
    chk("rd10_rdata", got_d, 32'hDEADBEEF);
    chk("rd10_err", got_e, 0);
    repeat (3) @(negedge clk);
    chk("two_pulses", rsp_cnt - base_rsp, 2);
    // partial strobe
    xact(1, 32'h20, 32'h11111111, 4'hF);
    xact(1, 32'h20, 32'hAABBCCDD, 4'h3);
    chk("wr20_strb_err", got_e, 0);
    xact(0, 32'h20, 0, 0);
    chk("rd20_merged", got_d, 32'h1111CCDD);
    // awready stalled 5 cycles, wready immediate
    aw_wait = 5;
    @(negedge clk);
    base_rsp = rsp_cnt; base_aw = aw_hi; base_w = w_hi; base_mv = aw_moves;
    xact(1, 32'h30, 32'h12345678, 4'hF);
    chk("stall_valid", got_v, 1);
    chk("stall_timeout", got_t, 0);
    repeat (4) @(negedge clk);
    chk("stall_aw_cycles", aw_hi - base_aw, 6);
    chk("stall_w_cycles", w_hi - base_w, 1);
    chk("stall_awaddr_stable", aw_moves - base_mv, 0);
    chk("stall_one_rsp", rsp_cnt - base_rsp, 1);
    aw_wait = 0;
    xact(0, 32'h30, 0, 0);
    chk("stall_readback", got_d, 32'h12345678);
    // SLVERR read
    r_err = 1;
    xact(0, 32'h40, 0, 0);
    chk("slverr_valid", got_v, 1);
    chk("slverr_err", got_e, 1);
    chk("slverr_timeout", got_t, 0);
    r_err = 0;
    // timeout on a dead AR channel, then drain
    ar_block = 1;
    @(negedge clk);
    base_rsp = rsp_cnt;
    xact(0, 32'h50, 0, 0);
    chk("to_valid", got_v, 1);
    chk("to_latency", got_lat, 16);
    chk("to_flag", got_t, 1);
    chk("to_err", got_e, 1);
    chk("to_rdata", got_d, 0);
    @(negedge clk);
    chk("drain_busy", req_ready, 0);
    chk("drain_arvalid_held", axi.arvalid, 1);
    ar_block = 0;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    chk("drain_exit", req_ready, 1);
    repeat (3) @(negedge clk);
    chk("drain_no_extra_rsp", rsp_cnt - base_rsp, 1);
    chk("drain_rready_low", axi.rready, 0);
    // reset while awvalid is high
    aw_wait = 5;
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 32'h60; req_wdata = 32'h55; req_wstrb = 4'hF;
    @(negedge clk);
    req_valid = 0;
    chk("pre_rst_awvalid", axi.awvalid, 1);
    rst = 1;
    #1;
    chk("rst_awvalid_async", axi.awvalid, 0);
    chk("rst_req_ready", req_ready, 1);
    @(negedge clk);
    rst = 0;
    aw_wait = 3;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    // request held high across busy cycles is accepted once
    base_acc = acc_cnt;
    req_valid = 1; req_write = 1; req_addr = 32'h70; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
    chk("held_rsp_valid", rsp_valid, 1);
    req_valid = 0;
    repeat (3) @(negedge clk);
    chk("held_accept_once", acc_cnt - base_acc, 1);
    aw_wait = 0;
    xact(0, 32'h70, 0, 0);
    chk("held_readback", got_d, 32'hCAFEF00D);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
